// File: rtl/gemm_pkg.sv
// Shared types and constants for the GEMM tile scheduler.
package gemm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        WRITE,
        DONE
    } sched_state_t;

    // Cycles between the last operand read and the final product landing in acc:
    // one for the SRAM read, one for the multiplier register.
    localparam int unsigned DRAIN_CYCLES = 2;

    // Index counter width for a dimension of size n (at least one bit).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gemm_idx_cnt.sv
// Nested i/j/k loop counters for the tile scheduler.
// k steps once per operand read; i/j step once per accepted C write (row-major).
module gemm_idx_cnt
    import gemm_pkg::*;
#(
    parameter int unsigned MATRIX_WIDTH  = 4,
    parameter int unsigned MATRIX_HEIGHT = 4,
    parameter int unsigned MATRIX_ADJUST = 4
) (
    input  logic                               iclk,
    input  logic                               irst,
    input  logic                               k_step,
    input  logic                               ij_step,
    output logic [idx_w(MATRIX_ADJUST)-1:0]    k_idx,
    output logic [idx_w(MATRIX_WIDTH)-1:0]     j_idx,
    output logic [idx_w(MATRIX_HEIGHT)-1:0]    i_idx,
    output logic                               k_last,
    output logic                               j_last,
    output logic                               i_last
);

    localparam int unsigned KW = idx_w(MATRIX_ADJUST);
    localparam int unsigned JW = idx_w(MATRIX_WIDTH);
    localparam int unsigned IW = idx_w(MATRIX_HEIGHT);

    assign k_last = (k_idx == KW'(MATRIX_ADJUST - 1));
    assign j_last = (j_idx == JW'(MATRIX_WIDTH - 1));
    assign i_last = (i_idx == IW'(MATRIX_HEIGHT - 1));

    // Wrapping counters: k on its own enable, j carrying into i on the ij enable.
    always_ff @(posedge iclk) begin
        if (irst) begin
            k_idx <= '0;
            j_idx <= '0;
            i_idx <= '0;
        end else begin
            if (k_step) begin
                k_idx <= k_last ? '0 : k_idx + KW'(1);
            end
            if (ij_step) begin
                if (j_last) begin
                    j_idx <= '0;
                    i_idx <= i_last ? '0 : i_idx + IW'(1);
                end else begin
                    j_idx <= j_idx + JW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/gemm_tile_sched.sv
// GEMM tile scheduler: reads A/B operands, feeds the registered tile multiplier,
// accumulates products over k and writes each C element on a valid/ready port.
module gemm_tile_sched
    import gemm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned MATRIX_WIDTH  = 4,
    parameter int unsigned MATRIX_HEIGHT = 4,
    parameter int unsigned MATRIX_ADJUST = 4,
    parameter int unsigned ADDR_WIDTH    = 8
) (
    input  logic                  iclk,
    input  logic                  irst,
    input  logic                  istart,
    output logic                  obusy,
    output logic                  odone,
    output logic                  ord_en,
    output logic [ADDR_WIDTH-1:0] oa_addr,
    output logic [ADDR_WIDTH-1:0] ob_addr,
    input  logic [DATA_WIDTH-1:0] ia_data,
    input  logic [DATA_WIDTH-1:0] ib_data,
    output logic [DATA_WIDTH-1:0] oa_tile,
    output logic [DATA_WIDTH-1:0] ob_tile,
    input  logic [DATA_WIDTH-1:0] iprod,
    output logic                  oc_valid,
    input  logic                  ic_ready,
    output logic [ADDR_WIDTH-1:0] oc_addr,
    output logic [DATA_WIDTH-1:0] oc_data
);

    localparam int unsigned KW = idx_w(MATRIX_ADJUST);
    localparam int unsigned JW = idx_w(MATRIX_WIDTH);
    localparam int unsigned IW = idx_w(MATRIX_HEIGHT);

    sched_state_t          state;
    logic [1:0]            drain_cnt;
    logic [DATA_WIDTH-1:0] acc;
    logic                  v0;
    logic                  v1;

    logic [KW-1:0] k_idx;
    logic [JW-1:0] j_idx;
    logic [IW-1:0] i_idx;
    logic          k_last;
    logic          j_last;
    logic          i_last;
    logic          handshake;

    assign handshake = (state == WRITE) && ic_ready;

    gemm_idx_cnt #(
        .MATRIX_WIDTH  (MATRIX_WIDTH),
        .MATRIX_HEIGHT (MATRIX_HEIGHT),
        .MATRIX_ADJUST (MATRIX_ADJUST)
    ) u_idx_cnt (
        .iclk    (iclk),
        .irst    (irst),
        .k_step  (state == ISSUE),
        .ij_step (handshake),
        .k_idx   (k_idx),
        .j_idx   (j_idx),
        .i_idx   (i_idx),
        .k_last  (k_last),
        .j_last  (j_last),
        .i_last  (i_last)
    );

    // Outputs decode only registered state and counters (no input-to-output paths
    // except the operand pass-through to the multiplier).
    assign obusy    = (state != IDLE);
    assign odone    = (state == DONE);
    assign ord_en   = (state == ISSUE);
    assign oc_valid = (state == WRITE);
    assign oc_data  = acc;
    assign oa_addr  = ADDR_WIDTH'(i_idx) * ADDR_WIDTH'(MATRIX_ADJUST) + ADDR_WIDTH'(k_idx);
    assign ob_addr  = ADDR_WIDTH'(k_idx) * ADDR_WIDTH'(MATRIX_WIDTH) + ADDR_WIDTH'(j_idx);
    assign oc_addr  = ADDR_WIDTH'(i_idx) * ADDR_WIDTH'(MATRIX_WIDTH) + ADDR_WIDTH'(j_idx);
    assign oa_tile  = ia_data;
    assign ob_tile  = ib_data;

    // Valid pipe tracking read data (v0) and multiplier output (v1).
    always_ff @(posedge iclk) begin
        if (irst) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
        end else begin
            v0 <= ord_en;
            v1 <= v0;
        end
    end

    // Sequencer FSM plus accumulator; entering ISSUE overrides the accumulate with a clear.
    always_ff @(posedge iclk) begin
        if (irst) begin
            state     <= IDLE;
            drain_cnt <= '0;
            acc       <= '0;
        end else begin
            if (v1) begin
                acc <= acc + iprod;
            end
            case (state)
                IDLE: begin
                    if (istart) begin
                        state <= ISSUE;
                        acc   <= '0;
                    end
                end
                ISSUE: begin
                    if (k_last) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 2'(DRAIN_CYCLES - 1)) begin
                        state <= WRITE;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                WRITE: begin
                    if (ic_ready) begin
                        if (i_last && j_last) begin
                            state <= DONE;
                        end else begin
                            state <= ISSUE;
                            acc   <= '0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
